// File: rtl/btb_target_buffer_if.sv
// Bus bundle between the branch history table / pipeline and the branch
// target buffer. The BTB_STATS_EN macro adds the hit/miss counter outputs.
interface btb_target_buffer_if;
    logic        search_i;
    logic [31:0] b_pc;
    logic        hit_o;
    logic [31:0] target_o;
    logic        upd_en_i;
    logic        inv_en_i;
    logic [31:0] mem_pc;
    logic [31:0] mem_target;
    logic        flush_i;
    logic        busy_o;
`ifdef BTB_STATS_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;
`endif

    // Pipeline side: drives requests, observes lookup results.
    modport master (
        output search_i, b_pc, upd_en_i, inv_en_i, mem_pc, mem_target, flush_i,
        input  hit_o, target_o, busy_o
`ifdef BTB_STATS_EN
        , input hit_cnt_o, miss_cnt_o
`endif
    );

    // BTB side.
    modport slave (
        input  search_i, b_pc, upd_en_i, inv_en_i, mem_pc, mem_target, flush_i,
        output hit_o, target_o, busy_o
`ifdef BTB_STATS_EN
        , output hit_cnt_o, miss_cnt_o
`endif
    );
endinterface

// File: rtl/btb_target_buffer.sv
// Direct-mapped branch target buffer with combinational lookup, MEM-stage
// update/invalidate, same-cycle write forwarding and a sequential
// whole-table flush engine (one entry per cycle).
// Optional build macro BTB_STATS_EN adds saturating hit/miss counters.
module btb_target_buffer #(
    parameter int BTB_SIZE = 256,
    parameter int IDX_W    = 8,
    parameter int TAG_W    = 22
) (
    input  logic                 clk,
    input  logic                 rst_ni,
    btb_target_buffer_if.slave   bus
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [BTB_SIZE-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [BTB_SIZE];
    logic [31:0]         tgt_q [BTB_SIZE];

    logic [IDX_W-1:0] b_idx, m_idx;
    logic [TAG_W-1:0] b_tag, m_tag;
    logic             busy;
    logic             wr_ok;
    logic             upd_ok;
    logic             inv_ok;
    logic             same_line;
    logic             hit;
    logic [31:0]      target;
    logic             unused_pc_bits;

    assign b_idx = bus.b_pc[IDX_W+1:2];
    assign b_tag = bus.b_pc[31:IDX_W+2];
    assign m_idx = bus.mem_pc[IDX_W+1:2];
    assign m_tag = bus.mem_pc[31:IDX_W+2];

    // Word-aligned PCs: the byte-offset bits never take part in indexing.
    assign unused_pc_bits = ^{bus.b_pc[1:0], bus.mem_pc[1:0]};

    assign busy = (state_q == FLUSH);

    // MEM-stage writes are dropped while flushing and on the accepting cycle.
    assign wr_ok     = ~busy & ~bus.flush_i;
    assign upd_ok    = bus.upd_en_i & wr_ok;
    assign inv_ok    = bus.inv_en_i & ~bus.upd_en_i & wr_ok & (tag_q[m_idx] == m_tag);
    assign same_line = (m_idx == b_idx) && (m_tag == b_tag);

    // Lookup with forwarding of a same-cycle update or invalidate.
    always_comb begin
        hit    = 1'b0;
        target = 32'h0;
        if (rst_ni && bus.search_i && !busy) begin
            if (upd_ok && same_line) begin
                hit    = 1'b1;
                target = bus.mem_target;
            end else if (inv_ok && same_line) begin
                hit    = 1'b0;
            end else if (valid_q[b_idx] && (tag_q[b_idx] == b_tag)) begin
                hit    = 1'b1;
                target = tgt_q[b_idx];
            end
        end
    end

    assign bus.hit_o    = hit;
    assign bus.target_o = target;
    assign bus.busy_o   = busy;

    // Flush FSM next state: walk every index once, then return to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.flush_i) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(BTB_SIZE - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Flush FSM state and counter registers.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Valid-bit next state: flush clear has priority, then update, then invalidate.
    always_comb begin
        valid_d = valid_q;
        if (busy) begin
            valid_d[cnt_q] = 1'b0;
        end else if (upd_ok) begin
            valid_d[m_idx] = 1'b1;
        end else if (inv_ok) begin
            valid_d[m_idx] = 1'b0;
        end
    end

    // Valid bits are the only reset storage.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and target arrays: written on accepted updates, never reset.
    always_ff @(posedge clk) begin
        if (upd_ok) begin
            tag_q[m_idx] <= m_tag;
            tgt_q[m_idx] <= bus.mem_target;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Saturating hit/miss counters over searches made while not flushing.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (bus.search_i && !busy) begin
            if (hit) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    // Counter registers; a flush leaves them untouched.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.hit_cnt_o  = hit_cnt_q;
    assign bus.miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: doc/btb_target_buffer.md
Name: btb_target_buffer

Overview:
- Branch Target Buffer: the responder to the branch history table's taken-prediction search request.
- When the history table asserts search_i (its T_NT output) for the fetch-stage PC, this block returns hit_o and the predicted target address in the same cycle.
- Entries are written or invalidated from the MEM stage once a branch resolves.
- Includes a sequential whole-table flush engine for context switches and self-modifying-code events.

Parameters:
- BTB_SIZE, 256, number of entries; power of two.
- IDX_W, 8, index width, log2(BTB_SIZE); index = pc[IDX_W+1:2].
- TAG_W, 22, tag width = 32-IDX_W-2; tag = pc[31:IDX_W+2].

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_ni  in  1  asynchronous active-low reset.
- search_i  in  1  lookup request from the history table (T_NT).
- b_pc  in  32  fetch-stage PC to look up.
- hit_o  out  1  valid, tag-matching entry found for b_pc while search_i=1.
- target_o  out  32  predicted target; 0 when hit_o=0.
- upd_en_i  in  1  MEM-stage branch resolved taken: write entry.
- inv_en_i  in  1  MEM-stage branch resolved not-taken after a BTB hit: invalidate entry.
- mem_pc  in  32  MEM-stage branch PC.
- mem_target  in  32  resolved branch target, written when upd_en_i=1.
- flush_i  in  1  pulse: invalidate all entries.
- busy_o  out  1  flush in progress.

Behaviour:
Storage
- Per entry: valid bit, tag (TAG_W bits), target (32 bits).
- Only valid bits are reset; tag and target arrays are not reset.
- Reads are combinational (asynchronous).
- Writes take effect on posedge clk.

Reset (rst_ni=0, asynchronous)
- All valid bits cleared; FSM goes to IDLE; flush counter cleared.
- Outputs during reset: hit_o=0, target_o=0, busy_o=0.

Lookup (combinational)
- hit_o = search_i & ~busy_o & valid[idx(b_pc)] & (tag[idx] == tag(b_pc)).
- target_o = stored target when hit_o=1, else 0.
- Write-forwarding: if upd_en_i=1, not busy, idx(mem_pc)==idx(b_pc) and tag(mem_pc)==tag(b_pc) in the same cycle, then hit_o=search_i and target_o=mem_target.
- Same-cycle invalidate of the looked-up entry forces hit_o=0.

Update (posedge)
- upd_en_i=1: valid←1, tag←tag(mem_pc), target←mem_target at idx(mem_pc). Overwrites any aliasing entry (direct-mapped replacement).
- inv_en_i=1: valid←0 at idx(mem_pc), only if the stored tag matches tag(mem_pc); otherwise no effect.
- upd_en_i and inv_en_i both 1: update wins, invalidate ignored.

Flush FSM
- States: IDLE, FLUSH.
- IDLE→FLUSH when flush_i=1. Counter←0, busy_o=1 from the next cycle.
- FLUSH: each cycle clears valid[cnt] and increments cnt.
- Leaves FLUSH after clearing entry BTB_SIZE-1. Total BTB_SIZE cycles with busy_o=1, then IDLE.
- flush_i while in FLUSH is ignored; no restart.
- upd_en_i and inv_en_i are dropped (not queued) while busy_o=1 and on the cycle flush_i is accepted.
- Reset mid-flush: asynchronous return to IDLE; all valid bits are 0 anyway.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - Each cycle with search_i=1 and busy_o=0 increments hit_cnt_o if hit_o=1, else miss_cnt_o.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0. Flush does not clear them.
- Undefined: no counters, no extra ports. Lookup, update and flush behaviour are identical in both builds.

Test Plan:
- Reset, then search_i=1, b_pc=0x0000_0040 → hit_o=0, target_o=0.
- upd_en_i=1, mem_pc=0x0000_0040, mem_target=0x0000_0100; next cycle search_i=1, b_pc=0x40 → hit_o=1, target_o=0x100. b_pc=0x440 (same index, different tag) → hit_o=0.
- Same-cycle update and lookup of 0x80 → target 0x200 → hit_o=1, target_o=0x200 combinationally in that cycle (forwarding).
- Entry 0x40 valid; inv_en_i with mem_pc=0x440 → entry survives (tag mismatch). inv_en_i with mem_pc=0x40 → next lookup hit_o=0. upd_en_i and inv_en_i together on 0x40 → entry valid.
- Fill 4 entries, pulse flush_i → busy_o=1 for exactly 256 cycles. Hit_o=0 and updates ignored during flush; afterwards all lookups miss. Assert rst_ni=0 at flush cycle 100 → busy_o=0 immediately.
- BTB_STATS_EN: 3 hits and 2 misses → hit_cnt_o=3, miss_cnt_o=2. Searches during flush are not counted. Preload 0xFFFF_FFFF via force → count holds at 0xFFFF_FFFF.
